// File: rtl/basys3_score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : basys3_score_display_ctrl
// Description : Converts a binary game score into four BCD digits with a
//               serial double-dabble engine (one bit per clock), saturates at
//               9999, applies leading-zero blanking and presents registered
//               digits and enables to the seven-segment driver.
//               Optional blink support is compiled in with DISP_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module basys3_score_display_ctrl #(
    parameter int SCORE_W   = 14,
    parameter int BLINK_DIV = 250
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic               score_valid_i,
    input  logic               blank_i,
    input  logic               blink_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         digit0_o,
    output logic [3:0]         digit1_o,
    output logic [3:0]         digit2_o,
    output logic [3:0]         digit3_o,
    output logic               digit0_en_o,
    output logic               digit1_en_o,
    output logic               digit2_en_o,
    output logic               digit3_en_o
);

    localparam int                 c_cnt_w    = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(SCORE_W - 1);
    localparam logic [31:0]        c_sat_max  = 32'd9999;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [SCORE_W-1:0] r_bin;
    logic [15:0]        r_bcd;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pend;
    logic [SCORE_W-1:0] r_pend_val;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_digits;
    logic [3:0]         r_lz_en;
    logic [3:0]         r_en;

    logic [SCORE_W-1:0] w_score_sat;
    logic [15:0]        w_bcd_adj;
    logic [3:0]         w_lz_new;
    logic [3:0]         w_lz_sel;
    logic               w_show;

    // Clamp the incoming score to the four-digit range; a narrow score never trips this.
    always_comb begin
        w_score_sat = score_i;
        if (32'(score_i) > c_sat_max) begin
            w_score_sat = c_sat_max[SCORE_W-1:0];
        end
    end

    // Double-dabble correction: add 3 to every nibble of 5 or more before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking from the finished conversion; the enable set
    // switches in the same edge the digits are published.
    always_comb begin
        w_lz_new[3] = |r_bcd[15:12];
        w_lz_new[2] = |r_bcd[15:8];
        w_lz_new[1] = |r_bcd[15:4];
        w_lz_new[0] = 1'b1;
        w_lz_sel    = (r_state == c_st_done) ? w_lz_new : r_lz_en;
    end

`ifdef DISP_BLINK_EN
    localparam int                   c_blink_w    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_on;

    // Blink phase generator; idles in the "on" phase while no blink is requested.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!blink_i) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_show = ~blank_i & ~(blink_i & ~r_blink_on);
`else
    logic w_unused;
    assign w_unused = &{1'b0, blink_i, BLINK_DIV[0]};
    assign w_show   = ~blank_i;
`endif

    // Conversion sequencer: capture, serial shift, publish, chain the pending value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_st_idle;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_digits   <= '0;
            r_lz_en    <= 4'b0001;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (score_valid_i) begin
                        r_bin   <= w_score_sat;
                        r_bcd   <= '0;
                        r_cnt   <= c_cnt_load;
                        r_busy  <= 1'b1;
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_bcd <= {w_bcd_adj[14:0], r_bin[SCORE_W-1]};
                    r_bin <= r_bin << 1;
                    if (r_cnt == '0) begin
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    // Newest request wins; the running conversion is untouched.
                    if (score_valid_i) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_score_sat;
                    end
                end
                c_st_done: begin
                    r_digits <= r_bcd;
                    r_lz_en  <= w_lz_new;
                    r_done   <= 1'b1;
                    // A strobe landing on this edge is newer than anything
                    // pending, so it supersedes the pending value directly.
                    if (score_valid_i || r_pend) begin
                        r_bin   <= score_valid_i ? w_score_sat : r_pend_val;
                        r_bcd   <= '0;
                        r_cnt   <= c_cnt_load;
                        r_pend  <= 1'b0;
                        r_state <= c_st_shift;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Final enables: blanking pattern gated by blank (and blink), registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en <= 4'b0001;
        end else begin
            r_en <= w_lz_sel & {4{w_show}};
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign digit0_o    = r_digits[3:0];
    assign digit1_o    = r_digits[7:4];
    assign digit2_o    = r_digits[11:8];
    assign digit3_o    = r_digits[15:12];
    assign digit0_en_o = r_en[0];
    assign digit1_en_o = r_en[1];
    assign digit2_en_o = r_en[2];
    assign digit3_en_o = r_en[3];

endmodule
`default_nettype wire
